// File: rtl/paula_regs_pkg.sv
// rtl/paula_regs_pkg.sv - Paula serial-port register indices, SERDATR bits and sequencer states

package paula_regs_pkg;

    // Custom-register word indices presented on rga_o
    localparam logic [7:0] REG_SERDATR = 8'h0C;
    localparam logic [7:0] REG_SERDAT  = 8'h18;
    localparam logic [7:0] REG_SERPER  = 8'h19;
    localparam logic [7:0] REG_INTREQ  = 8'h4E;
    localparam logic [7:0] REG_NONE    = 8'hFF;

    // SERDATR status bit positions
    localparam int SERDATR_OVRUN = 15;
    localparam int SERDATR_RBF   = 14;
    localparam int SERDATR_TBE   = 13;

    // INTREQ write with SET/CLR=0 and only the RBF bit set clears RBF
    localparam logic [15:0] INTREQ_RBF_CLR = 16'h0800;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_POLL,
        ST_WRITE,
        ST_RXREAD,
        ST_RXACK
    } sched_state_t;

    // SERDAT word for 8-bit mode: data byte followed by one stop bit
    function automatic logic [15:0] serdat_word(input logic [7:0] b);
        return {7'b0, 1'b1, b};
    endfunction

endpackage

// File: rtl/paula_uart_sched_rr_arb2.sv
// rtl/paula_uart_sched_rr_arb2.sv - two-way round-robin arbiter with pointer update on accept

module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    input  logic       i_accept_idx,
    output logic       o_gnt_valid,
    output logic       o_gnt_idx
);

    // Requester served most recently; resets to 1 so requester 0 wins first
    logic r_last;

    // Pointer moves to the accepted requester, only on enabled slots
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (reset) begin
                r_last <= 1'b1;
            end else if (i_accept) begin
                r_last <= i_accept_idx;
            end
        end
    end

    // Grant the requester that was not served last when both ask
    always_comb begin
        o_gnt_valid = |i_req;
        if (i_req[0] && i_req[1]) begin
            o_gnt_idx = ~r_last;
        end else begin
            o_gnt_idx = i_req[1];
        end
    end

endmodule

// File: rtl/paula_uart_sched.sv
// rtl/paula_uart_sched.sv - Paula serial-port register-bus sequencer (SERPER, TX arbitration, RX drain)

module paula_uart_sched
    import paula_regs_pkg::*;
#(
    parameter logic [14:0] PER_RESET = 15'd61
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    output logic [7:0]  rga_o,
    output logic [15:0] bus_do,
    input  logic [15:0] bus_di,
    input  logic        rxint,
    input  logic [14:0] per_val,
    input  logic        per_load,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        rx_ovrun,
    output logic        busy
);

    // The state names the bus access currently presented; outputs are
    // registered from the next state so the access and state line up.
    sched_state_t r_state;
    sched_state_t w_next;

    logic [14:0] r_per_reg;
    logic        r_per_pend;
    logic        r_rx_pend;
    logic        r_gnt_idx;
    logic [7:0]  r_tx_byte;

    logic [7:0]  r_rga;
    logic [15:0] r_do;
    logic        r_ready0;
    logic        r_ready1;
    logic        r_rx_valid;
    logic [7:0]  r_rx_data;
    logic        r_rx_ovrun;
    logic        r_busy;

    logic [7:0]  w_rga;
    logic [15:0] w_do;
    logic        w_ready0;
    logic        w_ready1;
    logic        w_rx_req;
    logic        w_enter_rx;
    logic        w_enter_init;
    logic        w_enter_poll;
    logic        w_accept;
    logic        w_gnt_valid;
    logic        w_gnt_idx;
    logic        w_unused;

    // SERDATR bits this sequencer has no use for
    assign w_unused = &{1'b0, bus_di[SERDATR_RBF], bus_di[12:8]};

    rr_arb2 u_arb (
        .clk          (clk),
        .reset        (reset),
        .i_en         (clk7_en),
        .i_req        ({req1_valid, req0_valid}),
        .i_accept     (w_accept),
        .i_accept_idx (r_gnt_idx),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt_idx    (w_gnt_idx)
    );

    // Next-state selection and the bus access that the next slot presents
    always_comb begin
        w_next       = r_state;
        w_enter_rx   = 1'b0;
        w_enter_init = 1'b0;
        w_enter_poll = 1'b0;
        w_rx_req     = r_rx_pend | rxint;

        case (r_state)
            // First slot after reset shows FF; present SERPER once, then idle
            ST_INIT:   if (r_rga == REG_SERPER) w_next = ST_IDLE;
            ST_IDLE: begin
                if (w_rx_req) begin
                    w_next     = ST_RXREAD;
                    w_enter_rx = 1'b1;
                end else if (r_per_pend) begin
                    w_next       = ST_INIT;
                    w_enter_init = 1'b1;
                end else if (w_gnt_valid) begin
                    w_next       = ST_POLL;
                    w_enter_poll = 1'b1;
                end
            end
            ST_POLL:   w_next = bus_di[SERDATR_TBE] ? ST_WRITE : ST_IDLE;
            ST_WRITE:  w_next = ST_IDLE;
            ST_RXREAD: w_next = ST_RXACK;
            ST_RXACK:  w_next = ST_IDLE;
            default:   w_next = ST_INIT;
        endcase

        w_accept = (r_state == ST_POLL) && (w_next == ST_WRITE);

        w_rga    = REG_NONE;
        w_do     = 16'h0000;
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        case (w_next)
            ST_INIT: begin
                w_rga = REG_SERPER;
                w_do  = {1'b0, r_per_reg};
            end
            ST_POLL:   w_rga = REG_SERDATR;
            ST_WRITE: begin
                w_rga    = REG_SERDAT;
                w_do     = serdat_word(r_tx_byte);
                w_ready0 = ~r_gnt_idx;
                w_ready1 = r_gnt_idx;
            end
            ST_RXREAD: w_rga = REG_SERDATR;
            ST_RXACK: begin
                w_rga = REG_INTREQ;
                w_do  = INTREQ_RBF_CLR;
            end
            default: begin
                w_rga = REG_NONE;
                w_do  = 16'h0000;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                r_state <= ST_INIT;
            end else begin
                r_state <= w_next;
            end
        end
    end

    // Registered bus access, handshake strobes and received-byte capture
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                r_rga      <= REG_NONE;
                r_do       <= 16'h0000;
                r_ready0   <= 1'b0;
                r_ready1   <= 1'b0;
                r_rx_valid <= 1'b0;
                r_rx_data  <= 8'h00;
                r_rx_ovrun <= 1'b0;
                r_busy     <= 1'b1;
            end else begin
                r_rga      <= w_rga;
                r_do       <= w_do;
                r_ready0   <= w_ready0;
                r_ready1   <= w_ready1;
                r_busy     <= (w_next != ST_IDLE);
                r_rx_valid <= (r_state == ST_RXREAD);
                if (r_state == ST_RXREAD) begin
                    r_rx_data  <= bus_di[7:0];
                    r_rx_ovrun <= bus_di[SERDATR_OVRUN];
                end
            end
        end
    end

    // Pending flags, period register and the TX grant/byte latched at POLL entry
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                r_per_reg  <= PER_RESET;
                r_per_pend <= 1'b0;
                r_rx_pend  <= 1'b0;
                r_gnt_idx  <= 1'b0;
                r_tx_byte  <= 8'h00;
            end else begin
                if (per_load) begin
                    r_per_reg  <= per_val;
                    r_per_pend <= 1'b1;
                end else if (w_enter_init) begin
                    r_per_pend <= 1'b0;
                end
                // Entering RXREAD consumes one interrupt; a second one in the same slot stays pending
                if (w_enter_rx) begin
                    r_rx_pend <= r_rx_pend & rxint;
                end else if (rxint) begin
                    r_rx_pend <= 1'b1;
                end
                if (w_enter_poll) begin
                    r_gnt_idx <= w_gnt_idx;
                    r_tx_byte <= w_gnt_idx ? req1_data : req0_data;
                end
            end
        end
    end

    assign rga_o      = r_rga;
    assign bus_do     = r_do;
    assign req0_ready = r_ready0;
    assign req1_ready = r_ready1;
    assign rx_valid   = r_rx_valid;
    assign rx_data    = r_rx_data;
    assign rx_ovrun   = r_rx_ovrun;
    assign busy       = r_busy;

endmodule

// File: doc/paula_uart_sched.md
# paula_uart_sched

Register-bus sequencer for the Paula serial port: programs SERPER, arbitrates two byte-stream requesters onto SERDAT with TBE polling, and drains received characters via SERDATR with RBF acknowledge through INTREQ. It sits between on-chip byte producers/consumers (debug console, host bridge) and the Paula custom-register bus, using the same `clk7_en` slot as the serial port.

## Interface
- `PER_RESET`, default 15'd61, SERPER value loaded after reset (8-bit mode, LONG=0).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high, sampled only when `clk7_en`=1.
- `clk7_en` in 1: bus slot enable; all state advances only when high.
- `rga_o` out 8: register address (word index); 8'hFF when idle.
- `bus_do` out 16: write data to serial port.
- `bus_di` in 16: read data (SERDATR word) from serial port.
- `rxint` in 1: one-slot receive interrupt pulse.
- `per_val` in 15: new period value. `per_load` in 1: request SERPER reload.
- `req0_valid` in 1, `req0_data` in 8, `req0_ready` out 1: TX requester 0.
- `req1_valid` in 1, `req1_data` in 8, `req1_ready` out 1: TX requester 1.
- `rx_valid` out 1: one-slot strobe with received byte. `rx_data` out 8. `rx_ovrun` out 1: OVRUN flag captured with byte.
- `busy` out 1: state not IDLE.

## Operation
- Address constants: SERPER 8'h19, SERDAT 8'h18, SERDATR 8'h0C, INTREQ 8'h4E.
- States: INIT, IDLE, POLL, WRITE, RXREAD, RXACK.
- INIT: `rga_o`=SERPER, `bus_do`={1'b0, per_reg} -> IDLE. `per_reg` resets to PER_RESET; `per_load` in any state updates `per_reg`<=`per_val` and sets `per_pend`.
- IDLE priority: `rx_pend` > `per_pend` > TX. `per_pend` -> INIT (clears `per_pend`). TX candidate -> POLL.
- `rx_pend` set on `rxint`, cleared on entering RXREAD; set wins if both in the same slot.
- POLL: `rga_o`=SERDATR; if `bus_di[13]` (TBE)=1 -> WRITE, else -> IDLE (retry; RX may interleave).
- WRITE: `rga_o`=SERDAT, `bus_do`={7'b0, 1'b1, byte}; selected `reqN_ready`=1 this slot only -> IDLE.
- Arbitration: round-robin, pointer `last` (reset 1, so req0 wins first). Grant latched on POLL entry and held until WRITE; the requester must keep `valid`/`data` stable until `ready`. A requester dropping `valid` before WRITE: WRITE still sends the latched byte (bytes are latched at POLL entry).
- RXREAD: `rga_o`=SERDATR; `rx_data`<=`bus_di[7:0]`, `rx_ovrun`<=`bus_di[15]`, `rx_valid`=1 next slot -> RXACK.
- RXACK: `rga_o`=INTREQ, `bus_do`=16'h0800 (clear RBF) -> IDLE.

## Timing
- Reset values: `rga_o`=8'hFF, `bus_do`=0, `req*_ready`=0, `rx_valid`=0, `rx_data`=0, `rx_ovrun`=0, `busy`=1 (state INIT).
- All outputs registered; one bus access per enabled slot; `rga_o`=8'hFF and `bus_do`=0 in IDLE.
- Minimum TX cost: 3 slots (IDLE, POLL, WRITE). RX drain: IDLE -> RXREAD -> RXACK; `rx_valid` asserted in the RXACK slot.
- `clk7_en` low: all registers hold; strobes extend until the next enabled edge (consumers qualify with `clk7_en`).
- Reset in mid-operation: returns to INIT; pending byte dropped, no `ready`; `rx_pend` cleared.

## Structure
- Shared package `paula_regs_pkg`: register word indices (SERPER, SERDAT, SERDATR, INTREQ), SERDATR bit positions (OVRUN 15, RBF 14, TBE 13), INTREQ RBF mask.
- One sub-module: `rr_arb2` (2-way round-robin, grant + pointer update on accept).

## Test plan
- Reset, `clk7_en` every 4th clk -> first enabled slot writes SERPER with 16'h003D, then `rga_o`=8'hFF.
- req0 0x41, TBE=1 -> POLL reads 8'h0C, WRITE puts 16'h0141 at 8'h18, `req0_ready` for one slot.
- req0 and req1 held valid continuously -> grants alternate 0,1,0,1; TBE=0 -> repeated POLL, no WRITE, no ready.
- `rxint` with `bus_di`=16'hC05A -> `rx_data`=8'h5A, `rx_ovrun`=1, then INTREQ write 16'h0800.
- `rxint` and req1 in the same idle slot -> RXREAD/RXACK first, then POLL/WRITE for req1.
- `per_load` 15'd372 mid-TX, reset mid-POLL -> SERPER 16'h0174 after the TX; after reset, INIT with PER_RESET and no `ready`.
